register_file: RTL and testbench

//   Processor general-purpose register file: 2 combinational read ports, 1 synchronous write port.
//   The highest-numbered address is not storage; it aliases the external R15 input (PC value from fetch).

---
 rtl/register_file.sv | 51 +++++
 tb/tb_register_file.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Decode-stage register file: two combinational read ports and one synchronous write port.
// The top index has no storage and returns the external R15 (PC) input.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WE3,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    input  logic [ADDR_WIDTH-1:0] A3,
    input  logic [DATA_WIDTH-1:0] WD3,
    input  logic [DATA_WIDTH-1:0] R15,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int NUM_STORED = NUM_REGS - 1;
    localparam logic [ADDR_WIDTH-1:0] PC_IDX = '1;

    logic [DATA_WIDTH-1:0] r_regs [NUM_STORED];
    logic                  w_wr_en;

    // Writes aimed at the PC alias are dropped; it has no backing register.
    assign w_wr_en = WE3 && (A3 != PC_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STORED; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[A3] <= WD3;
        end
    end

    // No write-through bypass: a same-address read sees the new value only after the edge.
    always_comb begin
        RD1 = R15;
        RD2 = R15;
        if (A1 != PC_IDX) begin
            RD1 = r_regs[A1];
        end
        if (A2 != PC_IDX) begin
            RD2 = r_regs[A2];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed checks of reset, PC alias, write timing and async reset,
// followed by randomized traffic against an array-based reference model.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        WE3;
    logic [2:0]  A1;
    logic [2:0]  A2;
    logic [2:0]  A3;
    logic [31:0] WD3;
    logic [31:0] R15;
    logic [31:0] RD1;
    logic [31:0] RD2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [7];

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .WE3 (WE3),
        .A1  (A1),
        .A2  (A2),
        .A3  (A3),
        .WD3 (WD3),
        .R15 (R15),
        .RD1 (RD1),
        .RD2 (RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a, input logic [31:0] pc);
        if (a == 3'd7) return pc;
        return model[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 7; i++) model[i] = 32'h0;
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 7; i++) begin
            A1 = i[2:0];
            A2 = 3'(6 - i);
            #1;
            check({tag, "_rd1"}, RD1, model[i]);
            check({tag, "_rd2"}, RD2, model[6 - i]);
        end
    endtask

    initial begin
        logic [3:0] wide_addr;
        rst = 1'b0; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0; R15 = 32'h0;
        model_clear();

        // 1. reset clears regs with no clock edge
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        check_all_regs("reset");

        // 2. PC alias follows R15 combinationally
        A1 = 3'd7; R15 = 32'h8;
        #1 check("alias_8", RD1, 32'h8);
        R15 = 32'h1234;
        #1 check("alias_1234", RD1, 32'h1234);

        // 3. write then read on both ports
        @(negedge clk);
        WE3 = 1'b1; A3 = 3'd3; WD3 = 32'hDEADBEEF;
        @(posedge clk); #1;
        model[3] = 32'hDEADBEEF;
        WE3 = 1'b0;
        A1 = 3'd3; A2 = 3'd3;
        #1;
        check("wr3_rd1", RD1, 32'hDEADBEEF);
        check("wr3_rd2", RD2, 32'hDEADBEEF);

        // 4. write to alias ignored
        @(negedge clk);
        WE3 = 1'b1; A3 = 3'd7; WD3 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        WE3 = 1'b0; R15 = 32'h20; A1 = 3'd7;
        #1 check("alias_wr_ign", RD1, 32'h20);
        check_all_regs("alias_wr_regs");

        // 5. write disable, then before/after edge timing
        @(negedge clk);
        WE3 = 1'b0; A3 = 3'd2; WD3 = 32'h55; A1 = 3'd2;
        @(posedge clk); #1;
        check("we0_reg2", RD1, 32'h0);
        @(negedge clk);
        WE3 = 1'b1;
        #1 check("pre_edge_reg2", RD1, 32'h0);
        @(posedge clk); #1;
        model[2] = 32'h55;
        check("post_edge_reg2", RD1, 32'h55);
        WE3 = 1'b0;

        // truncated wide address lands on the alias
        wide_addr = 4'b1111;
        A2 = wide_addr[2:0]; R15 = 32'hCAFE_0001;
        #1 check("trunc_alias", RD2, 32'hCAFE_0001);

        // 6. async reset mid-cycle after loading every register
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            WE3 = 1'b1; A3 = i[2:0]; WD3 = 32'h1000_0000 + i + 1;
            @(posedge clk); #1;
            model[i] = 32'h1000_0000 + i + 1;
        end
        WE3 = 1'b0;
        check_all_regs("loaded");
        @(negedge clk); #2;
        rst = 1'b1; R15 = 32'hABCD_0042;
        model_clear();
        #1;
        check_all_regs("async_rst");
        A1 = 3'd7;
        #1 check("async_rst_alias", RD1, 32'hABCD_0042);

        // reset dominates a write across a clock edge
        WE3 = 1'b1; A3 = 3'd4; WD3 = 32'h7777_7777; A1 = 3'd4;
        @(posedge clk); #1;
        check("rst_dominates", RD1, 32'h0);
        @(negedge clk);
        rst = 1'b0; WE3 = 1'b0;

        // randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            WE3 = 1'($urandom_range(0, 1));
            A1  = 3'($urandom_range(0, 7));
            A2  = 3'($urandom_range(0, 7));
            A3  = 3'($urandom_range(0, 7));
            WD3 = $urandom;
            R15 = $urandom;
            #1;
            check("rand_pre_rd1", RD1, model_read(A1, R15));
            check("rand_pre_rd2", RD2, model_read(A2, R15));
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                model_clear();
                #1;
                check("rand_rst_rd1", RD1, model_read(A1, R15));
                rst = 1'b0;
            end
            @(posedge clk);
            if (WE3 && A3 != 3'd7) model[A3] = WD3;
            #1;
            check("rand_post_rd1", RD1, model_read(A1, R15));
            check("rand_post_rd2", RD2, model_read(A2, R15));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
